// File: rtl/sig_lu_rom_half_act.sv
// Neuron activation stage: sigmoid by lookup table, or ReLU, with a single register stage.
//
// The sigmoid table is built at elaboration from an integer fixed-point evaluation of
// 1/(1+exp(-t)), so no real arithmetic reaches synthesis. Two table layouts are available.
// "sigmoid_LU_half" stores only the non-negative half and mirrors negative inputs as
// 2^FRAC - P(|x|). "sigmoid_nor" stores the full odd-symmetric table.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset; clears out and out_valid
//   in_valid   qualifies sum
//   sum        signed accumulator, 2*DATA_WIDTH bits, 2*FRAC fractional bits
//   out_valid  in_valid delayed by one clock
//   out        activation result, FRAC fractional bits, unsigned; holds while idle
module sig_lu_rom_half_act #(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned WEIGHT_INT_WIDTH = 4,
  parameter int unsigned SIGMOID_SIZE     = 10,
  parameter string       ACT_TYPE         = "sigmoid_LU_half"
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [2*DATA_WIDTH-1:0]   sum,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out
);

  localparam int unsigned DW          = DATA_WIDTH;
  localparam int unsigned WIW         = WEIGHT_INT_WIDTH;
  localparam int unsigned S           = SIGMOID_SIZE;
  localparam int unsigned FRAC        = DW - WIW;
  // Fractional bits of the table index.
  localparam int unsigned SF          = S - WIW;
  localparam int unsigned HalfEntries = 2 ** (S - 1);
  localparam int unsigned FullEntries = 2 ** S;
  // Working precision of the table generator.
  localparam int unsigned QBits       = 60;
  localparam logic [DW-1:0] FracOne   = DW'(2 ** FRAC);

  // P(m) = round-half-up(2^FRAC / (1 + exp(-m / 2^SF))), evaluated in Q.QBits integers.
  function automatic logic [DW-1:0] sig_pos(input int unsigned m);
    logic [127:0] one;
    logic [127:0] term;
    logic [127:0] base;
    logic [127:0] acc;
    logic [127:0] den;
    logic [127:0] num;
    logic [127:0] quo;
    int unsigned  e;
    one  = 128'd1 << QBits;
    term = one;
    base = one;
    // exp(-2^-SF) by Taylor series; terms shrink by 2^SF per step.
    for (int k = 1; k < 24; k++) begin
      term = (term >> SF) / 128'(k);
      if ((k % 2) == 1) base = base - term;
      else              base = base + term;
    end
    // exp(-m / 2^SF) = base^m by square-and-multiply.
    acc = one;
    e   = m;
    while (e != 0) begin
      if ((e & 1) != 0) acc = (acc * base) >> QBits;
      base = (base * base) >> QBits;
      e    = e >> 1;
    end
    den = one + acc;
    // floor(2^FRAC / (1+exp) + 1/2) as floor((2*2^FRAC*one + den) / (2*den)).
    num = (128'd1 << (FRAC + QBits + 1)) + den;
    quo = num / (den << 1);
    return quo[DW-1:0];
  endfunction

  // Full sigmoid F(x) for a signed table code, with the most-negative code clamped.
  function automatic logic [DW-1:0] sig_full(input int x);
    int unsigned m;
    if (x < 0) begin
      m = (x == -int'(HalfEntries)) ? HalfEntries - 1 : unsigned'(-x);
      return FracOne - sig_pos(m);
    end
    return sig_pos(unsigned'(x));
  endfunction

  logic          unused_sum;
  logic [DW-1:0] act_val;
  logic [DW-1:0] out_q;
  logic          out_valid_q;

  // Not every accumulator bit feeds every activation.
  assign unused_sum = ^sum;

  if (ACT_TYPE == "sigmoid_LU_half") begin : g_half
    logic [DW-1:0] rom_half [HalfEntries];
    logic [S-1:0]  x;
    logic [S-1:0]  x_neg;
    logic [S-2:0]  m;
    logic [DW-1:0] p;

    for (genvar gi = 0; gi < HalfEntries; gi++) begin : g_rom
      localparam logic [DW-1:0] PVal = sig_pos(gi);
      assign rom_half[gi] = PVal;
    end

    assign x     = sum[2*DW-1-WIW -: S];
    assign x_neg = -x;

    always_comb begin
      m = x[S-2:0];
      if (x[S-1]) begin
        // Negating the most-negative code overflows back to itself; clamp instead.
        m = x_neg[S-1] ? '1 : x_neg[S-2:0];
      end
      p       = rom_half[m];
      act_val = x[S-1] ? (FracOne - p) : p;
    end
  end else if (ACT_TYPE == "sigmoid_nor") begin : g_nor
    logic [DW-1:0] rom_full [FullEntries];
    logic [S-1:0]  x;
    logic [S-1:0]  idx;

    for (genvar gi = 0; gi < FullEntries; gi++) begin : g_rom
      localparam logic [DW-1:0] FVal = sig_full(gi - int'(HalfEntries));
      assign rom_full[gi] = FVal;
    end

    assign x   = sum[2*DW-1-WIW -: S];
    // Offset-binary index: x + 2^(S-1).
    assign idx = {~x[S-1], x[S-2:0]};

    always_comb begin
      act_val = rom_full[idx];
    end
  end else if (ACT_TYPE == "relu") begin : g_relu
    logic neg;
    logic over;

    assign neg  = sum[2*DW-1];
    // Any set bit between DW-1+FRAC and the sign means sum >= 2^(DW-1+FRAC).
    assign over = |sum[2*DW-2:DW-1+FRAC];

    always_comb begin
      act_val = sum[DW+FRAC-1:FRAC];
      if (neg) begin
        act_val = '0;
      end else if (over) begin
        act_val = {1'b0, {(DW-1){1'b1}}};
      end
    end
  end else begin : g_pass
    always_comb begin
      act_val = sum[DW+FRAC-1:FRAC];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_q <= act_val;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sig_lu_rom_half_act.sv
// Bench for sig_lu_rom_half_act: three instances (half-table sigmoid, full-table sigmoid,
// ReLU) share one input stream; expectations come from a real-arithmetic model and a
// table of known values, queued at drive time and compared one clock later.
module tb_sig_lu_rom_half_act;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] sum;
  logic        vld_h, vld_n, vld_r;
  logic [15:0] out_h, out_n, out_r;

  int compared;
  int mismatched;

  logic [15:0] q_h[$];
  logic [15:0] q_n[$];
  logic [15:0] q_r[$];
  logic [15:0] hold_h, hold_n, hold_r;

  sig_lu_rom_half_act #(.ACT_TYPE("sigmoid_LU_half")) u_half (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out_valid(vld_h), .out(out_h)
  );
  sig_lu_rom_half_act #(.ACT_TYPE("sigmoid_nor")) u_nor (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out_valid(vld_n), .out(out_n)
  );
  sig_lu_rom_half_act #(.ACT_TYPE("relu")) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out_valid(vld_r), .out(out_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] sig_model(input logic [31:0] s);
    logic [9:0] xb;
    int         x;
    int         m;
    int         p;
    real        r;
    xb = s[27:18];
    x  = int'($signed(xb));
    m  = (x < 0) ? -x : x;
    if (m > 511) m = 511;
    r = 4096.0 / (1.0 + $exp(-real'(m) / 64.0));
    p = $rtoi(r + 0.5);
    return (x < 0) ? 16'(4096 - p) : 16'(p);
  endfunction

  function automatic logic [15:0] relu_model(input logic [31:0] s);
    if ($signed(s) < 0) return 16'h0000;
    if (s >= 32'h0800_0000) return 16'h7FFF;
    return s[27:12];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] obs, inout logic [15:0] q[$],
                         output logic [15:0] got);
    if (q.size() == 0) begin
      compared++;
      mismatched++;
      got = 16'h0;
      $error("FAIL %s: observed %0h expected queued result (queue empty)", tag, obs);
    end else begin
      got = q.pop_front();
      chk(tag, obs, got);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
  task automatic step(input logic v, input logic [31:0] s);
    in_valid = v;
    sum      = s;
    if (v) begin
      q_h.push_back(sig_model(s));
      q_n.push_back(sig_model(s));
      q_r.push_back(relu_model(s));
    end
    @(negedge clk);
    chk("valid_half", 16'(vld_h), 16'(v));
    chk("valid_nor", 16'(vld_n), 16'(v));
    chk("valid_relu", 16'(vld_r), 16'(v));
    if (v) begin
      pop_chk("out_half", out_h, q_h, hold_h);
      pop_chk("out_nor", out_n, q_n, hold_n);
      pop_chk("out_relu", out_r, q_r, hold_r);
    end else begin
      chk("hold_half", out_h, hold_h);
      chk("hold_nor", out_n, hold_n);
      chk("hold_relu", out_r, hold_r);
    end
  endtask

  task automatic lit(input logic [31:0] s, input logic [15:0] sig_v, input logic [15:0] relu_v);
    step(1'b1, s);
    chk("known_half", out_h, sig_v);
    chk("known_nor", out_n, sig_v);
    chk("known_relu", out_r, relu_v);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vh"}, 16'(vld_h), 16'h0);
    chk({tag, "_vn"}, 16'(vld_n), 16'h0);
    chk({tag, "_vr"}, 16'(vld_r), 16'h0);
    chk({tag, "_oh"}, out_h, 16'h0);
    chk({tag, "_on"}, out_n, 16'h0);
    chk({tag, "_or"}, out_r, 16'h0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    hold_h     = 16'h0;
    hold_n     = 16'h0;
    hold_r     = 16'h0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    sum        = 32'h0;
    #1;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Known values: zero, +/-1.0, extremes and the clamped most-negative code.
    lit(32'h0000_0000, 16'd2048, 16'h0000);
    lit(32'h0100_0000, 16'd2994, 16'h1000);
    lit(32'hFF00_0000, 16'd1102, 16'h0000);
    lit(32'h07FC_0000, 16'd4095, 16'h7FC0);
    lit(32'hF800_0000, 16'd1, 16'h0000);
    lit(32'hF804_0000, 16'd1, 16'h0000);
    lit(32'hFFFF_FFFF, 16'd2032, 16'h0000);
    lit(32'h7FFF_FFFF, 16'd2032, 16'h7FFF);
    lit(32'h0000_0FFF, 16'd2048, 16'h0000);

    // Idle cycles hold the last result.
    step(1'b0, 32'h1234_5678);
    step(1'b0, 32'h0100_0000);

    // Eight back-to-back distinct inputs, then a gap.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(i * 32'h0053_1000) - 32'h0120_0000);
    end
    step(1'b0, 32'h0000_0000);

    // Every table code in order, both sigmoid layouts plus ReLU on the same inputs.
    for (int xi = -512; xi < 512; xi++) begin
      step(1'b1, (32'(xi) << 18) | 32'(xi & 32'h3FF));
    end

    // Reset pulled between edges after a result is out: clears at once.
    step(1'b1, 32'h0100_0000);
    in_valid = 1'b1;
    sum      = 32'h0200_0000;
    #2;
    rst = 1'b0;
    #1;
    chk_zero("rst_async");
    // An edge while held in reset with in_valid high leaves everything cleared.
    @(negedge clk);
    chk_zero("rst_held");
    hold_h = 16'h0;
    hold_n = 16'h0;
    hold_r = 16'h0;
    q_h.delete();
    q_n.delete();
    q_r.delete();

    // Release; the very next edge samples input normally.
    rst = 1'b1;
    step(1'b1, 32'hFF00_0000);
    step(1'b0, 32'h0000_0000);
    step(1'b1, 32'h0100_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sig_lu_rom_half_act.md
SIG_LU_ROM_HALF_ACT -- requirements
Module: sig_lu_rom_half

Interface
REQ-001 Parameter DATA_WIDTH, default 16: neuron data width (DW).
REQ-002 Parameter WEIGHT_INT_WIDTH, default 4: integer bits incl. sign (WIW); FRAC = DW-WIW = 12.
REQ-003 Parameter SIGMOID_SIZE, default 10: sigmoid table input width (S); S > WIW.
REQ-004 Parameter ACT_TYPE, default "sigmoid_LU_half": one of "sigmoid_LU_half", "sigmoid_nor", "relu".
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  sum qualifier.
REQ-009 sum  input  2*DW  signed accumulator, 2*FRAC fractional bits.
REQ-010 out_valid  output  1  out qualifier.
REQ-011 out  output  DW  activation result, FRAC fractional bits, unsigned.

Function
REQ-012 Latency exactly 1 clk: out/out_valid registered on the edge sampling in_valid/sum; out_valid = in_valid delayed 1.
REQ-013 out updates only when in_valid=1; otherwise holds. No backpressure; one result per cycle.
REQ-014 Sigmoid index x = sum[2*DW-1-WIW -: S], signed, x_real = x/2^(S-WIW) (WIW integer, S-WIW fractional bits).
REQ-015 sum bits above the slice are ignored (wrap, no saturation); keeping |sum| < 2^(WIW-1) is the caller's job.
REQ-016 Sign flag = x MSB; magnitude m = |x|, clamped to 2^(S-1)-1 for the most-negative code.
REQ-017 Sigmoid function F: P(m) = round-half-up(2^FRAC/(1+exp(-m/2^(S-WIW)))); F = P(m) for x>=0, F = 2^FRAC - P(m) for x<0.
REQ-018 "sigmoid_LU_half": ROM of 2^(S-1) entries holds P(m) indexed by m; negative inputs use subtractor 2^FRAC - P(m).
REQ-019 "sigmoid_nor": ROM of 2^S entries indexed by x + 2^(S-1) (MSB inverted) holding F directly; bit-identical to half mode for every x.
REQ-020 ROM contents computed at elaboration (function/generate or init file); synthesizable as LUT/ROM; no runtime writes.
REQ-021 "relu": out = 0 if sum<0; else sum[DW+FRAC-1:FRAC] (arithmetic >>FRAC, truncation); if sum >= 2^(DW-1+FRAC), saturate to 2^(DW-1)-1.
REQ-022 Invalid ACT_TYPE: out = sum[DW+FRAC-1:FRAC] registered (pass-through, no activation).
REQ-023 Sigmoid out range [1, 2^FRAC-1] except F(0)=2^(FRAC-1); never exceeds 2^FRAC.

Reset
REQ-024 rst low asynchronously forces out=0 and out_valid=0 immediately, regardless of clk.
REQ-025 After rst rises, first valid result appears 1 clk after first sampled in_valid; an input sampled in the same edge reset is released is processed normally.
REQ-026 Reset mid-stream discards the in-flight result; no partial output emitted.

Verification
REQ-027 Sigmoid (either mode, defaults): sum=0x0000_0000 -> out=2048; sum=0x0100_0000 (+1.0) -> 2994; sum=0xFF00_0000 (-1.0) -> 1102; out_valid 1 clk after in_valid.
REQ-028 Sigmoid extremes: x=+511 (sum=0x07FC_0000) -> 4095; x=-512 (sum=0xF800_0000) -> 1 (clamp); x=-511 -> 1.
REQ-029 Equivalence: sweep all 1024 x codes in both sigmoid modes -> identical outputs, monotonic non-decreasing in x.
REQ-030 ReLU: sum=0x0100_0000 -> 0x1000; sum=0xFFFF_FFFF -> 0; sum=0x7FFF_FFFF -> 0x7FFF; sum=0x0000_0FFF -> 0.
REQ-031 Back-to-back in_valid for 8 cycles with distinct sums -> 8 consecutive correct outputs, in order; in_valid gap -> out holds, out_valid=0.
REQ-032 Assert rst low between clk edges mid-stream -> out=0, out_valid=0 instantly; release -> normal 1-cycle operation resumes.
